// File: rtl/crosshair_pkg.sv
// Shared definitions for the crosshair arbiter: ownership codes, the
// arbiter state enum, button bit positions and default screen geometry.
package crosshair_pkg;

  // Arbiter states: nobody owns the crosshair, or player 0 / player 1 does.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } state_t;

  // Encodings presented on the owner output.
  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_P0   = 2'b01;
  localparam logic [1:0] OWNER_P1   = 2'b10;

  // Bit positions inside each 4-bit {up, down, left, right} button vector.
  localparam int BTN_UP    = 3;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_RIGHT = 0;

  // Default geometry and motion tuning.
  localparam int DEF_X_INIT         = 400;
  localparam int DEF_Y_INIT         = 300;
  localparam int SCREEN_X_MIN       = 0;
  localparam int SCREEN_X_MAX       = 1023;
  localparam int SCREEN_Y_MIN       = 0;
  localparam int SCREEN_Y_MAX       = 767;
  localparam int DEF_DELTA_MIN      = 2;
  localparam int DEF_DELTA_MAX      = 8;
  localparam int DEF_ACCEL_FRAMES   = 4;
  localparam int DEF_RELEASE_FRAMES = 30;

  // Next step size when acceleration kicks in, never exceeding the ceiling.
  function automatic logic [3:0] stepUp(input logic [3:0] cur, input logic [3:0] lim);
    return (cur >= lim) ? lim : cur + 4'd1;
  endfunction

endpackage

// File: rtl/axis_clamp_step.sv
// One axis of crosshair motion: moves a position by a step toward the
// pressed direction and saturates at the inclusive bounds. Arithmetic is
// carried in 12 bits so the sum can never wrap before it is clamped.
module axis_clamp_step
  import crosshair_pkg::*;
#(
  parameter int W = 11
) (
  input  logic [W-1:0] i_pos,
  input  logic [3:0]   i_step,
  input  logic         i_inc,
  input  logic         i_dec,
  input  logic [W-1:0] i_min,
  input  logic [W-1:0] i_max,
  output logic [W-1:0] o_next
);

  logic [11:0] w_pos;
  logic [11:0] w_min;
  logic [11:0] w_max;
  logic [11:0] w_step;
  logic [11:0] w_sum;
  logic [11:0] w_floor;
  logic [11:0] w_res;

  assign w_pos   = 12'(i_pos);
  assign w_min   = 12'(i_min);
  assign w_max   = 12'(i_max);
  assign w_step  = 12'(i_step);
  assign w_sum   = w_pos + w_step;
  assign w_floor = w_min + w_step;

  // Pick the saturated new position; opposing or absent presses hold still.
  always_comb begin
    w_res = w_pos;
    if (i_inc && !i_dec) begin
      w_res = (w_sum > w_max) ? w_max : w_sum;
    end else if (i_dec && !i_inc) begin
      w_res = (w_pos < w_floor) ? w_min : (w_pos - w_step);
    end
  end

  assign o_next = W'(w_res);

endmodule

// File: rtl/crosshair_arbiter.sv
// Owns the shared crosshair position. Two players compete for control via
// their button vectors; one owner at a time moves the crosshair once per
// frame (falling edge of vsync) with a hold-to-accelerate step ramp.
module crosshair_arbiter
  import crosshair_pkg::*;
#(
  parameter int X_INIT         = DEF_X_INIT,
  parameter int Y_INIT         = DEF_Y_INIT,
  parameter int X_MIN          = SCREEN_X_MIN,
  parameter int X_MAX          = SCREEN_X_MAX,
  parameter int Y_MIN          = SCREEN_Y_MIN,
  parameter int Y_MAX          = SCREEN_Y_MAX,
  parameter int DELTA_MIN      = DEF_DELTA_MIN,
  parameter int DELTA_MAX      = DEF_DELTA_MAX,
  parameter int ACCEL_FRAMES   = DEF_ACCEL_FRAMES,
  parameter int RELEASE_FRAMES = DEF_RELEASE_FRAMES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vsync,
  input  logic        enable,
  input  logic        recenter,
  input  logic [3:0]  btn0,
  input  logic [3:0]  btn1,
  output logic [10:0] x_pos,
  output logic [9:0]  y_pos,
  output logic [1:0]  owner,
  output logic [3:0]  step
);

  // Counters only need to reach N-1 because they clear on the frame they hit N.
  localparam int HW = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
  localparam int RW = (RELEASE_FRAMES > 1) ? $clog2(RELEASE_FRAMES) : 1;

  state_t          r_state;
  state_t          w_stateNext;
  logic            r_vsync;
  logic            r_lastOwner;
  logic [HW-1:0]   r_hold;
  logic [RW-1:0]   r_release;
  logic [3:0]      r_step;
  logic [10:0]     r_x;
  logic [9:0]      r_y;

  logic            w_tick;
  logic            w_req0;
  logic            w_req1;
  logic [3:0]      w_ownBtn;
  logic            w_owned;
  logic            w_moving;
  logic            w_accelDone;
  logic            w_releaseDone;
  logic [10:0]     w_xNext;
  logic [9:0]      w_yNext;

  assign w_tick        = r_vsync & ~vsync;
  assign w_req0        = |btn0;
  assign w_req1        = |btn1;
  assign w_ownBtn      = (r_state == ST_OWN1) ? btn1 : btn0;
  assign w_owned       = (r_state != ST_IDLE);
  assign w_moving      = enable & w_tick & w_owned & (|w_ownBtn);
  assign w_accelDone   = (r_hold == HW'(ACCEL_FRAMES - 1));
  assign w_releaseDone = (r_release == RW'(RELEASE_FRAMES - 1));

  // Keep one cycle of vsync history so its falling edge becomes the frame tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vsync <= 1'b0;
    end else begin
      r_vsync <= vsync;
    end
  end

  // Arbiter state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Grant on a frame tick from IDLE; drop the owner after enough idle frames.
  always_comb begin
    w_stateNext = r_state;
    if (!enable) begin
      w_stateNext = ST_IDLE;
    end else if (w_tick) begin
      case (r_state)
        ST_IDLE: begin
          if (w_req0 && w_req1) begin
            w_stateNext = r_lastOwner ? ST_OWN0 : ST_OWN1;
          end else if (w_req0) begin
            w_stateNext = ST_OWN0;
          end else if (w_req1) begin
            w_stateNext = ST_OWN1;
          end
        end
        ST_OWN0, ST_OWN1: begin
          if (!(|w_ownBtn) && w_releaseDone) begin
            w_stateNext = ST_IDLE;
          end
        end
        default: w_stateNext = ST_IDLE;
      endcase
    end
  end

  // Owner code is decoded straight from the state flops.
  always_comb begin
    case (r_state)
      ST_OWN0: owner = OWNER_P0;
      ST_OWN1: owner = OWNER_P1;
      default: owner = OWNER_NONE;
    endcase
  end

  // Step ramp, hold/release counters and the fairness memory of who owned last.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_step      <= 4'(DELTA_MIN);
      r_hold      <= '0;
      r_release   <= '0;
      r_lastOwner <= 1'b1;
    end else if (!enable) begin
      r_step    <= 4'(DELTA_MIN);
      r_hold    <= '0;
      r_release <= '0;
    end else if (w_tick) begin
      if (!w_owned) begin
        r_step    <= 4'(DELTA_MIN);
        r_hold    <= '0;
        r_release <= '0;
      end else if (w_moving) begin
        r_release <= '0;
        if (w_accelDone) begin
          r_hold <= '0;
          r_step <= stepUp(r_step, 4'(DELTA_MAX));
        end else begin
          r_hold <= r_hold + HW'(1);
        end
      end else begin
        r_step <= 4'(DELTA_MIN);
        r_hold <= '0;
        if (w_releaseDone) begin
          r_release   <= '0;
          r_lastOwner <= (r_state == ST_OWN1);
        end else begin
          r_release <= r_release + RW'(1);
        end
      end
    end
  end

  // Crosshair position: recenter wins over any motion in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x <= 11'(X_INIT);
      r_y <= 10'(Y_INIT);
    end else if (recenter) begin
      r_x <= 11'(X_INIT);
      r_y <= 10'(Y_INIT);
    end else if (w_moving) begin
      r_x <= w_xNext;
      r_y <= w_yNext;
    end
  end

  axis_clamp_step #(.W(11)) u_xAxis (
    .i_pos  (r_x),
    .i_step (r_step),
    .i_inc  (w_ownBtn[BTN_RIGHT]),
    .i_dec  (w_ownBtn[BTN_LEFT]),
    .i_min  (11'(X_MIN)),
    .i_max  (11'(X_MAX)),
    .o_next (w_xNext)
  );

  axis_clamp_step #(.W(10)) u_yAxis (
    .i_pos  (r_y),
    .i_step (r_step),
    .i_inc  (w_ownBtn[BTN_DOWN]),
    .i_dec  (w_ownBtn[BTN_UP]),
    .i_min  (10'(Y_MIN)),
    .i_max  (10'(Y_MAX)),
    .o_next (w_yNext)
  );

  assign x_pos = r_x;
  assign y_pos = r_y;
  assign step  = r_step;

endmodule

// File: tb/tb_crosshair_arbiter.sv
// Bench for crosshair_arbiter: directed scenarios followed by randomized
// button traffic, all compared against a frame-level reference model.
module tb_crosshair_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        vsync;
  logic        enable;
  logic        recenter;
  logic [3:0]  btn0;
  logic [3:0]  btn1;
  logic [10:0] x_pos;
  logic [9:0]  y_pos;
  logic [1:0]  owner;
  logic [3:0]  step;

  int checks = 0;
  int failures = 0;

  // Reference model state, expressed as plain integers.
  int mX;
  int mY;
  int mOwner;
  int mStep;
  int mHold;
  int mRel;
  int mLast;
  bit mEnable;

  crosshair_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .vsync    (vsync),
    .enable   (enable),
    .recenter (recenter),
    .btn0     (btn0),
    .btn1     (btn1),
    .x_pos    (x_pos),
    .y_pos    (y_pos),
    .owner    (owner),
    .step     (step)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  function automatic int clampInt(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic modelReset();
    mX = 400; mY = 300; mOwner = 0; mStep = 2; mHold = 0; mRel = 0; mLast = 2;
  endtask

  task automatic modelRecenter();
    mX = 400; mY = 300;
  endtask

  // One frame of the arbitration and motion rules.
  task automatic modelTick(input logic [3:0] b0, input logic [3:0] b1);
    logic [3:0] b;
    int dx;
    int dy;
    if (mEnable) begin
      if (mOwner == 0) begin
        if (b0 != 0 && b1 != 0) mOwner = (mLast == 1) ? 2 : 1;
        else if (b0 != 0) mOwner = 1;
        else if (b1 != 0) mOwner = 2;
        mStep = 2; mHold = 0; mRel = 0;
      end else begin
        b = (mOwner == 1) ? b0 : b1;
        if (b != 0) begin
          dx = int'(b[0]) - int'(b[1]);
          dy = int'(b[2]) - int'(b[3]);
          mX = clampInt(mX + dx * mStep, 0, 1023);
          mY = clampInt(mY + dy * mStep, 0, 767);
          mRel = 0;
          mHold = mHold + 1;
          if (mHold == 4) begin
            mStep = (mStep < 8) ? mStep + 1 : 8;
            mHold = 0;
          end
        end else begin
          mRel = mRel + 1;
          mStep = 2;
          mHold = 0;
          if (mRel == 30) begin
            mLast = mOwner;
            mOwner = 0;
            mRel = 0;
          end
        end
      end
    end
  endtask

  task automatic checkOne(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkOne({tag, ".x"}, 16'(x_pos), 16'(mX));
    checkOne({tag, ".y"}, 16'(y_pos), 16'(mY));
    checkOne({tag, ".owner"}, 16'(owner), 16'(mOwner));
    checkOne({tag, ".step"}, 16'(step), 16'(mStep));
  endtask

  // Drive one video frame; optionally pulse recenter in the tick cycle itself.
  task automatic applyStimulus(input logic [3:0] b0, input logic [3:0] b1, input bit rc);
    btn0 = b0;
    btn1 = b1;
    @(negedge clk) vsync = 1'b1;
    @(negedge clk) begin
      vsync = 1'b0;
      recenter = rc;
    end
    @(negedge clk) recenter = 1'b0;
    modelTick(b0, b1);
    if (rc) modelRecenter();
  endtask

  // Directed steps followed by random traffic.
  initial begin
    logic [3:0] rb0;
    logic [3:0] rb1;
    int holdLeft;
    int satFrames;
    bit rc;

    reset = 1'b1; vsync = 1'b0; enable = 1'b1; recenter = 1'b0;
    btn0 = 4'b0000; btn1 = 4'b0000;
    mEnable = 1'b1;
    modelReset();
    #3;
    checkOutput("rstInit");
    @(negedge clk) reset = 1'b0;

    // Right held from reset: grant, then ramp.
    applyStimulus(4'b0001, 4'b0000, 1'b0);
    checkOutput("grant0");
    checkOne("grant0.xConst", 16'(x_pos), 16'd400);
    for (int i = 2; i <= 5; i++) begin
      applyStimulus(4'b0001, 4'b0000, 1'b0);
      checkOutput("ramp");
    end
    checkOne("t5.xConst", 16'(x_pos), 16'd408);
    checkOne("t5.stepConst", 16'(step), 16'd3);
    applyStimulus(4'b0001, 4'b0000, 1'b0);
    checkOutput("t6");
    checkOne("t6.xConst", 16'(x_pos), 16'd411);

    // Drive into the right edge and stay there.
    satFrames = 0;
    for (int i = 0; i < 160 && satFrames < 3; i++) begin
      applyStimulus(4'b0001, 4'b0000, 1'b0);
      checkOutput("right");
      if (mX == 1023) satFrames++;
    end
    checkOne("xSatConst", 16'(x_pos), 16'd1023);

    // Drive into the top edge without wrapping.
    satFrames = 0;
    for (int i = 0; i < 120 && satFrames < 3; i++) begin
      applyStimulus(4'b1000, 4'b0000, 1'b0);
      checkOutput("up");
      if (mY == 0) satFrames++;
    end
    checkOne("ySatConst", 16'(y_pos), 16'd0);

    // Recenter between ticks, then recenter colliding with a motion tick.
    @(negedge clk) recenter = 1'b1;
    @(negedge clk) recenter = 1'b0;
    modelRecenter();
    checkOutput("recenter");
    applyStimulus(4'b0001, 4'b0000, 1'b0);
    applyStimulus(4'b0001, 4'b0000, 1'b1);
    checkOutput("recenterTick");
    checkOne("recenterTick.xConst", 16'(x_pos), 16'd400);

    // Left+right cancel while up moves y.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b1011, 4'b0000, 1'b0);
      checkOutput("lrUp");
      checkOne("lrUp.xConst", 16'(x_pos), 16'd400);
    end

    // Reset mid-operation, away from any clock edge.
    applyStimulus(4'b0001, 4'b0000, 1'b0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 modelReset();
    checkOutput("asyncRst");
    btn0 = 4'b0001; btn1 = 4'b0100;
    @(negedge clk) reset = 1'b0;

    // Both request: player 0 wins since player 1 is remembered as last owner.
    applyStimulus(4'b0001, 4'b0100, 1'b0);
    checkOutput("arbBoth");
    checkOne("arbBoth.ownerConst", 16'(owner), 16'd1);
    for (int i = 1; i <= 31; i++) begin
      applyStimulus(4'b0000, 4'b0100, 1'b0);
      checkOutput("release");
      if (i == 29) checkOne("rel29.ownerConst", 16'(owner), 16'd1);
      if (i == 30) checkOne("rel30.ownerConst", 16'(owner), 16'd0);
    end
    checkOne("arbP1.ownerConst", 16'(owner), 16'd2);

    // Enable low drops ownership at once and freezes motion.
    @(negedge clk) enable = 1'b0;
    mEnable = 1'b0;
    mOwner = 0; mStep = 2; mHold = 0; mRel = 0;
    @(negedge clk);
    checkOutput("enOff");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0000, 4'b0101, 1'b0);
      checkOutput("enOffTick");
    end
    @(negedge clk) enable = 1'b1;
    mEnable = 1'b1;
    applyStimulus(4'b0000, 4'b0101, 1'b0);
    checkOutput("enOn");

    // Randomized traffic with held button patterns and occasional recenter.
    holdLeft = 0;
    rb0 = 4'b0000;
    rb1 = 4'b0000;
    for (int f = 0; f < 150; f++) begin
      if (holdLeft == 0) begin
        rb0 = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
        rb1 = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
        holdLeft = $urandom_range(1, 12);
      end
      holdLeft--;
      rc = ($urandom_range(0, 19) == 0);
      applyStimulus(rb0, rb1, rc);
      checkOutput("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/crosshair_arbiter.md
Name: crosshair_arbiter

Overview:
- Owns the shared crosshair position and arbitrates control of it between two button requesters (player 0, player 1), one owner at a time.
- Steps the crosshair once per video frame, with hold-to-accelerate speed ramp and saturating clamp at screen bounds.
- Sits between the debounced button logic and the crosshair/overlay renderer; runs on the system pixel clock and uses vsync only as a frame-tick source.

Parameters:
- X_INIT, 400, x position after reset/recenter
- Y_INIT, 300, y position after reset/recenter
- X_MIN, 0, left bound (inclusive)
- X_MAX, 1023, right bound (inclusive)
- Y_MIN, 0, top bound (inclusive)
- Y_MAX, 767, bottom bound (inclusive)
- DELTA_MIN, 2, initial step in pixels per frame
- DELTA_MAX, 8, maximum step in pixels per frame
- ACCEL_FRAMES, 4, moving frames per step increment
- RELEASE_FRAMES, 30, idle frames before owner loses grant

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- vsync  input  1  video vsync, synchronous to clk
- enable  input  1  movement enable; low forces IDLE, no motion
- recenter  input  1  one-cycle pulse, jump to X_INIT/Y_INIT
- btn0  input  4  player 0 {up, down, left, right}, debounced
- btn1  input  4  player 1 {up, down, left, right}, debounced
- x_pos  output  11  crosshair x
- y_pos  output  10  crosshair y
- owner  output  2  00 none, 01 player 0, 10 player 1
- step  output  4  current step size

Behaviour:
- Reset (async, active-high): x_pos=X_INIT, y_pos=Y_INIT, owner=00, step=DELTA_MIN, last_owner=player 1, hold and release counters 0, vsync history 0.
- Frame tick: vsync registered once; tick is a one-cycle pulse when registered vsync=1 and vsync=0 (falling edge). All arbitration, motion and counters update only on tick, except recenter and enable.
- States: IDLE, OWN0, OWN1.
  - IDLE, tick: req_n = any bit of btn_n. Only one requesting: grant it. Both requesting: grant the one that is not last_owner. Grant takes effect that tick; no motion on the grant tick. step=DELTA_MIN, counters cleared.
  - OWNn, tick, owner buttons nonzero: move, release counter cleared.
  - OWNn, tick, owner buttons zero: release counter +1, step=DELTA_MIN, hold counter cleared. When counter reaches RELEASE_FRAMES: go to IDLE, last_owner=n.
  - Non-owner buttons are ignored while OWNn; there is no preemption.
  - enable low, any cycle: next cycle state=IDLE, owner=00, step=DELTA_MIN, last_owner unchanged.
- Motion (tick in OWNn, owner buttons nonzero):
  - Per axis, opposing pair both pressed or both released: axis unchanged.
  - Right: x = min(x+step, X_MAX). Left: x = X_MIN if x < X_MIN+step, else x-step. Same rule for y (down = +).
  - Compute in 12 bits; no wrap-around ever.
- Acceleration: hold counter counts motion ticks. On the motion tick where it reaches ACCEL_FRAMES, step increments by 1 (saturating at DELTA_MAX) and the counter clears. The new step applies from the next tick.
- Latency: x_pos/y_pos/owner registered; valid the cycle after the tick.
- recenter: positions load X_INIT/Y_INIT next cycle. Has priority over a same-cycle motion; state, owner and step are unaffected.
- Reset mid-operation: outputs return to reset values immediately, independent of clk.

Decomposition:
- Shared package crosshair_pkg:
  - owner encodings (OWNER_NONE/P0/P1)
  - state enum
  - button bit indices (BTN_UP=3, BTN_DOWN=2, BTN_LEFT=1, BTN_RIGHT=0)
  - screen bound defaults
- One natural sub-module: axis_clamp_step. Inputs: position, step, inc, dec, min, max. Output: the next saturated position. Instantiated once for x and once for y.

Test Plan:
- Reset asserted between clk edges -> x_pos=400, y_pos=300, owner=00, step=2 without waiting for a clock edge.
- btn0=0001 held from reset -> owner=01 after tick 1, x unchanged; ticks 2-5 give x=402,404,406,408 with step 3; tick 6 gives x=411.
- btn0 and btn1 both nonzero from reset -> owner=01, since last_owner resets to player 1. Release btn0, hold btn1 -> owner stays 01 for 30 ticks, goes to 00 on tick 30, then 10 on the next tick.
- x=1020 with step=8, right held -> x=1023 and stays 1023. y=3 with step=8, up held -> y=0, no wrap.
- btn0=0011 (left+right) with up held (btn0=1011) -> x unchanged, y decreases by step each tick.
- recenter pulse while moving right at x=600 -> x=400, y=300 next cycle; owner and step unchanged. enable low -> owner=00 next cycle, no motion on following ticks.
